dec_alu_issue: RTL and testbench

- Decode-side producer for the EXE-stage ALU.
- Takes RV32I ALU instructions plus register-file operands from DEC and decodes them into the ALU command set: 2-bit CMD, operands OP1/OP2 and carry-in CIN.
- Results are buffered in a small FIFO that EXE pops.
- SUB is lowered to OP1 + ~OP2 + 1, so EXE needs only ADD/AND/OR/XOR.

---
 rtl/river_pkg.sv | 53 +++++
 rtl/dec_alu_issue_decode.sv | 82 ++++++++
 rtl/dec_alu_issue.sv | 130 +++++++++++++
 tb/tb_dec_alu_issue.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/river_pkg.sv
// -----------------------------------------------------------------------------
// river_pkg
// Shared types and constants for the decode-side ALU issue path.
//   alu_cmd_t   : 2-bit command understood by the EXE-stage ALU.
//   OPC_*       : RV32I major opcodes handled here.
//   F3_* / F7_* : funct3 / funct7 field values for the supported ALU ops.
//   alu_issue_t : one decoded ALU command as stored in the issue FIFO.
// -----------------------------------------------------------------------------
package river_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_AND = 2'b01,
        ALU_OR  = 2'b10,
        ALU_XOR = 2'b11
    } alu_cmd_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic        cin;
        alu_cmd_t    cmd;
        logic [4:0]  rd;
        logic        wb;
        logic        illegal;
    } alu_issue_t;

    // True for the funct3 values that map directly onto an ALU command.
    function automatic logic f3_supported(input logic [2:0] f3);
        return (f3 == F3_ADD) || (f3 == F3_XOR) || (f3 == F3_OR) || (f3 == F3_AND);
    endfunction

    function automatic alu_cmd_t f3_to_cmd(input logic [2:0] f3);
        case (f3)
            F3_XOR:  return ALU_XOR;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/dec_alu_issue_decode.sv
// -----------------------------------------------------------------------------
// dec_alu_decode
// Purely combinational decoder: turns an RV32I ALU instruction and its register
// operands into an alu_issue_t. SUB is lowered to op1 + ~op2 + 1 so EXE only
// needs ADD/AND/OR/XOR. Unsupported encodings produce an all-zero command with
// illegal set.
//   instr    : instruction word
//   rs1_data : rs1 register value
//   rs2_data : rs2 register value
//   issue    : decoded command
// -----------------------------------------------------------------------------
module dec_alu_decode
    import river_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output alu_issue_t  issue
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;

    logic        legal;
    logic [31:0] op2;
    logic        cin;
    alu_cmd_t    cmd;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};

    // The rs1 field is resolved upstream; only its data is consumed here.
    logic unused_rs1_field;
    assign unused_rs1_field = ^instr[19:15];

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        legal = 1'b0;
        op2   = rs2_data;
        cin   = 1'b0;
        cmd   = ALU_ADD;
        issue = '0;

        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE && f3_supported(funct3)) begin
                    legal = 1'b1;
                    cmd   = f3_to_cmd(funct3);
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    // SUB: two's-complement negate rs2 via inversion + carry-in.
                    legal = 1'b1;
                    op2   = ~rs2_data;
                    cin   = 1'b1;
                end
            end
            OPC_OPIMM: begin
                if (f3_supported(funct3)) begin
                    legal = 1'b1;
                    op2   = imm_i;
                    cmd   = f3_to_cmd(funct3);
                end
            end
            default: ;
        endcase

        issue.rd      = instr[11:7];
        issue.illegal = ~legal;
        if (legal) begin
            issue.op1 = rs1_data;
            issue.op2 = op2;
            issue.cin = cin;
            issue.cmd = cmd;
            issue.wb  = (instr[11:7] != 5'd0);
        end
    end

endmodule

// File: rtl/dec_alu_issue.sv
// -----------------------------------------------------------------------------
// dec_alu_issue
// Decode-side producer for the EXE-stage ALU. Decodes DEC's instruction and
// buffers the resulting command in a DEPTH-entry FIFO that EXE pops.
//   CLK, RESET_N         : clock (rising edge), async active-low reset
//   INSTR_SD, RS*_DATA_SD: instruction and operands from DEC
//   VALID_SD / FULL_SD   : DEC push handshake (DEC holds while full)
//   FLUSH_SE             : discard all entries (wins over push/pop)
//   POP_SE / EMPTY_SE    : EXE pop handshake
//   OP1/OP2/CIN/CMD/RD/WB/ILLEGAL_SE : head entry, all zero while empty
// -----------------------------------------------------------------------------
module dec_alu_issue
    import river_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] INSTR_SD,
    input  logic [31:0] RS1_DATA_SD,
    input  logic [31:0] RS2_DATA_SD,
    input  logic        VALID_SD,
    output logic        FULL_SD,
    input  logic        FLUSH_SE,
    input  logic        POP_SE,
    output logic        EMPTY_SE,
    output logic [31:0] OP1_SE,
    output logic [31:0] OP2_SE,
    output logic        CIN_SE,
    output logic [1:0]  CMD_SE,
    output logic [4:0]  RD_SE,
    output logic        WB_SE,
    output logic        ILLEGAL_SE
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] CNT_FULL = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    alu_issue_t dec_issue;
    alu_issue_t head;
    alu_issue_t mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q,  count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    dec_alu_decode u_decode (
        .instr    (INSTR_SD),
        .rs1_data (RS1_DATA_SD),
        .rs2_data (RS2_DATA_SD),
        .issue    (dec_issue)
    );

    // Status comes from registered count only: no combinational path from
    // VALID_SD or POP_SE to FULL_SD/EMPTY_SE.
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign push  = VALID_SD & ~full;
    assign pop   = POP_SE & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (FLUSH_SE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + PW'(1);
                2'b01:   count_d = count_q - PW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their _d values from the same pre-edge snapshot.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; its contents are
    // never visible while empty, so resetting it would only add logic.
    always_ff @(posedge CLK) begin
        if (push && !FLUSH_SE) begin
            mem_q[wr_ptr_q[AW-1:0]] <= dec_issue;
        end
    end

    // Pointers wrap modulo DEPTH, so the top bit stays zero.
    logic unused_ptr_msb;
    assign unused_ptr_msb = wr_ptr_q[PW-1] ^ rd_ptr_q[PW-1];

    assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    assign FULL_SD    = full;
    assign EMPTY_SE   = empty;
    assign OP1_SE     = head.op1;
    assign OP2_SE     = head.op2;
    assign CIN_SE     = head.cin;
    assign CMD_SE     = head.cmd;
    assign RD_SE      = head.rd;
    assign WB_SE      = head.wb;
    assign ILLEGAL_SE = head.illegal;

endmodule

// File: tb/tb_dec_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_dec_alu_issue
// Self-checking bench for dec_alu_issue: a table of decode vectors, hand-written
// handshake/flush/reset sequences, then randomized traffic against a queue-based
// reference model that decodes by mnemonic and checks the EXE arithmetic result.
// -----------------------------------------------------------------------------
module tb_dec_alu_issue;

    localparam int DEPTH = 2;

    logic        CLK;
    logic        RESET_N;
    logic [31:0] INSTR_SD;
    logic [31:0] RS1_DATA_SD;
    logic [31:0] RS2_DATA_SD;
    logic        VALID_SD;
    logic        FULL_SD;
    logic        FLUSH_SE;
    logic        POP_SE;
    logic        EMPTY_SE;
    logic [31:0] OP1_SE;
    logic [31:0] OP2_SE;
    logic        CIN_SE;
    logic [1:0]  CMD_SE;
    logic [4:0]  RD_SE;
    logic        WB_SE;
    logic        ILLEGAL_SE;

    dec_alu_issue #(.DEPTH(DEPTH)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .INSTR_SD    (INSTR_SD),
        .RS1_DATA_SD (RS1_DATA_SD),
        .RS2_DATA_SD (RS2_DATA_SD),
        .VALID_SD    (VALID_SD),
        .FULL_SD     (FULL_SD),
        .FLUSH_SE    (FLUSH_SE),
        .POP_SE      (POP_SE),
        .EMPTY_SE    (EMPTY_SE),
        .OP1_SE      (OP1_SE),
        .OP2_SE      (OP2_SE),
        .CIN_SE      (CIN_SE),
        .CMD_SE      (CMD_SE),
        .RD_SE       (RD_SE),
        .WB_SE       (WB_SE),
        .ILLEGAL_SE  (ILLEGAL_SE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic        cin;
        logic [1:0]  cmd;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
        logic [31:0] res;   // value EXE should compute from this entry
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        exp_t        e;
    } vec_t;

    typedef enum {M_ADD, M_SUB, M_XOR, M_OR, M_AND,
                  M_ADDI, M_XORI, M_ORI, M_ANDI, M_BAD} mn_t;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs [11];
    exp_t model_q [$];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_e(input logic [31:0] op1, input logic [31:0] op2,
                                  input logic cin, input logic [1:0] cmd,
                                  input logic [4:0] rd, input logic wb,
                                  input logic ill, input logic [31:0] res);
        exp_t e;
        e.op1 = op1; e.op2 = op2; e.cin = cin; e.cmd = cmd;
        e.rd = rd; e.wb = wb; e.ill = ill; e.res = res;
        return e;
    endfunction

    function automatic vec_t mk_v(input logic [31:0] instr, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input exp_t e);
        vec_t v;
        v.instr = instr; v.rs1 = rs1; v.rs2 = rs2; v.e = e;
        return v;
    endfunction

    // What the EXE ALU computes from the current head outputs.
    function automatic logic [31:0] exe_result();
        case (CMD_SE)
            2'b00:   return OP1_SE + OP2_SE + {31'd0, CIN_SE};
            2'b01:   return OP1_SE & OP2_SE;
            2'b10:   return OP1_SE | OP2_SE;
            default: return OP1_SE ^ OP2_SE;
        endcase
    endfunction

    // Reference decode: identify the mnemonic, then build the command and the
    // architectural result it must produce.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] a,
                                        input logic [31:0] b);
        mn_t         mn;
        exp_t        e;
        logic [31:0] imm;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        imm = {{20{ins[31]}}, ins[31:20]};
        mn  = M_BAD;
        if (opc == 7'h33 && f7 == 7'h00) begin
            if (f3 == 3'd0) mn = M_ADD;
            if (f3 == 3'd4) mn = M_XOR;
            if (f3 == 3'd6) mn = M_OR;
            if (f3 == 3'd7) mn = M_AND;
        end
        if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd0) mn = M_SUB;
        if (opc == 7'h13) begin
            if (f3 == 3'd0) mn = M_ADDI;
            if (f3 == 3'd4) mn = M_XORI;
            if (f3 == 3'd6) mn = M_ORI;
            if (f3 == 3'd7) mn = M_ANDI;
        end
        e = mk_e(32'd0, 32'd0, 1'b0, 2'b00, ins[11:7], 1'b0, 1'b1, 32'd0);
        case (mn)
            M_ADD:  e = mk_e(a, b,    1'b0, 2'b00, ins[11:7], 1'b0, 1'b0, a + b);
            M_SUB:  e = mk_e(a, ~b,   1'b1, 2'b00, ins[11:7], 1'b0, 1'b0, a - b);
            M_XOR:  e = mk_e(a, b,    1'b0, 2'b11, ins[11:7], 1'b0, 1'b0, a ^ b);
            M_OR:   e = mk_e(a, b,    1'b0, 2'b10, ins[11:7], 1'b0, 1'b0, a | b);
            M_AND:  e = mk_e(a, b,    1'b0, 2'b01, ins[11:7], 1'b0, 1'b0, a & b);
            M_ADDI: e = mk_e(a, imm,  1'b0, 2'b00, ins[11:7], 1'b0, 1'b0, a + imm);
            M_XORI: e = mk_e(a, imm,  1'b0, 2'b11, ins[11:7], 1'b0, 1'b0, a ^ imm);
            M_ORI:  e = mk_e(a, imm,  1'b0, 2'b10, ins[11:7], 1'b0, 1'b0, a | imm);
            M_ANDI: e = mk_e(a, imm,  1'b0, 2'b01, ins[11:7], 1'b0, 1'b0, a & imm);
            default: ;
        endcase
        e.wb = !e.ill && (ins[11:7] != 5'd0);
        return e;
    endfunction

    task automatic check_head(input string tag, input exp_t e);
        check({tag, "_empty"}, {79'd0, EMPTY_SE},   80'd0);
        check({tag, "_op1"},   {48'd0, OP1_SE},     {48'd0, e.op1});
        check({tag, "_op2"},   {48'd0, OP2_SE},     {48'd0, e.op2});
        check({tag, "_cin"},   {79'd0, CIN_SE},     {79'd0, e.cin});
        check({tag, "_cmd"},   {78'd0, CMD_SE},     {78'd0, e.cmd});
        check({tag, "_rd"},    {75'd0, RD_SE},      {75'd0, e.rd});
        check({tag, "_wb"},    {79'd0, WB_SE},      {79'd0, e.wb});
        check({tag, "_ill"},   {79'd0, ILLEGAL_SE}, {79'd0, e.ill});
        if (!e.ill) check({tag, "_exe"}, {48'd0, exe_result()}, {48'd0, e.res});
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_empty"}, {79'd0, EMPTY_SE}, 80'd1);
        check({tag, "_full"},  {79'd0, FULL_SD},  80'd0);
        check({tag, "_zero"}, {6'd0, OP1_SE, OP2_SE, CIN_SE, CMD_SE, RD_SE, WB_SE, ILLEGAL_SE}, 80'd0);
    endtask

    task automatic drive(input vec_t v);
        INSTR_SD    = v.instr;
        RS1_DATA_SD = v.rs1;
        RS2_DATA_SD = v.rs2;
    endtask

    task automatic push_one(input vec_t v);
        drive(v);
        VALID_SD = 1'b1;
        @(negedge CLK);
        VALID_SD = 1'b0;
    endtask

    task automatic pop_one();
        POP_SE = 1'b1;
        @(negedge CLK);
        POP_SE = 1'b0;
    endtask

    initial begin
        logic [31:0] ins;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic        v;
        logic        p;
        logic        f;
        logic        do_push;
        logic        do_pop;

        vecs[0]  = mk_v(32'h002081B3, 32'd5, 32'd7,
                        mk_e(32'd5, 32'd7, 1'b0, 2'b00, 5'd3, 1'b1, 1'b0, 32'd12));
        vecs[1]  = mk_v(32'h402081B3, 32'd5, 32'd7,
                        mk_e(32'd5, 32'hFFFFFFF8, 1'b1, 2'b00, 5'd3, 1'b1, 1'b0, 32'hFFFFFFFE));
        vecs[2]  = mk_v(32'hFFF00213, 32'd0, 32'h1234,
                        mk_e(32'd0, 32'hFFFFFFFF, 1'b0, 2'b00, 5'd4, 1'b1, 1'b0, 32'hFFFFFFFF));
        vecs[3]  = mk_v(32'h0050C013, 32'hF0, 32'd9,
                        mk_e(32'hF0, 32'd5, 1'b0, 2'b11, 5'd0, 1'b0, 1'b0, 32'hF5));
        vecs[4]  = mk_v(32'h002091B3, 32'd5, 32'd7,
                        mk_e(32'd0, 32'd0, 1'b0, 2'b00, 5'd3, 1'b0, 1'b1, 32'd0));
        vecs[5]  = mk_v(32'h007372B3, 32'hFF00FF00, 32'h0FF00FF0,
                        mk_e(32'hFF00FF00, 32'h0FF00FF0, 1'b0, 2'b01, 5'd5, 1'b1, 1'b0, 32'h0F000F00));
        vecs[6]  = mk_v(32'h80016093, 32'h11, 32'd0,
                        mk_e(32'h11, 32'hFFFFF800, 1'b0, 2'b10, 5'd1, 1'b1, 1'b0, 32'hFFFFF811));
        vecs[7]  = mk_v(32'h7FF17F93, 32'hABCD1234, 32'd3,
                        mk_e(32'hABCD1234, 32'h7FF, 1'b0, 2'b01, 5'd31, 1'b1, 1'b0, 32'h234));
        vecs[8]  = mk_v(32'h4020C1B3, 32'd1, 32'd2,
                        mk_e(32'd0, 32'd0, 1'b0, 2'b00, 5'd3, 1'b0, 1'b1, 32'd0));
        vecs[9]  = mk_v(32'h000011B7, 32'd1, 32'd2,
                        mk_e(32'd0, 32'd0, 1'b0, 2'b00, 5'd3, 1'b0, 1'b1, 32'd0));
        vecs[10] = mk_v(32'h0041E133, 32'hA0, 32'h0A,
                        mk_e(32'hA0, 32'h0A, 1'b0, 2'b10, 5'd2, 1'b1, 1'b0, 32'hAA));

        RESET_N     = 1'b0;
        INSTR_SD    = '0;
        RS1_DATA_SD = '0;
        RS2_DATA_SD = '0;
        VALID_SD    = 1'b0;
        FLUSH_SE    = 1'b0;
        POP_SE      = 1'b0;
        repeat (2) @(negedge CLK);
        check_empty("reset");
        RESET_N = 1'b1;
        @(negedge CLK);

        // Table: push each vector alone, inspect the head, pop it.
        for (int i = 0; i < 11; i++) begin
            push_one(vecs[i]);
            check_head($sformatf("vec%0d", i), vecs[i].e);
            pop_one();
            check_empty($sformatf("vec%0d_pop", i));
        end

        // Three back-to-back pushes into a 2-deep FIFO; third is held.
        drive(vecs[0]); VALID_SD = 1'b1;
        @(negedge CLK);
        check("bb_full1", {79'd0, FULL_SD}, 80'd0);
        drive(vecs[5]);
        @(negedge CLK);
        check("bb_full2", {79'd0, FULL_SD}, 80'd1);
        drive(vecs[6]);
        @(negedge CLK);
        check("bb_held_full", {79'd0, FULL_SD}, 80'd1);
        check_head("bb_head_a", vecs[0].e);
        POP_SE = 1'b1;
        @(negedge CLK);
        POP_SE = 1'b0;
        check("bb_after_pop_full", {79'd0, FULL_SD}, 80'd0);
        check_head("bb_head_b", vecs[5].e);
        @(negedge CLK);
        VALID_SD = 1'b0;
        check("bb_third_in_full", {79'd0, FULL_SD}, 80'd1);
        pop_one();
        check_head("bb_head_c", vecs[6].e);
        // Push and pop together at count 1: count stays at 1.
        drive(vecs[10]); VALID_SD = 1'b1; POP_SE = 1'b1;
        @(negedge CLK);
        VALID_SD = 1'b0; POP_SE = 1'b0;
        check("pp_full", {79'd0, FULL_SD}, 80'd0);
        check_head("pp_head", vecs[10].e);
        pop_one();
        check_empty("pp_drained");

        // Flush with a full FIFO and a concurrent push/pop.
        push_one(vecs[0]);
        push_one(vecs[1]);
        check("fl_full", {79'd0, FULL_SD}, 80'd1);
        drive(vecs[7]); VALID_SD = 1'b1; POP_SE = 1'b1; FLUSH_SE = 1'b1;
        @(negedge CLK);
        VALID_SD = 1'b0; POP_SE = 1'b0; FLUSH_SE = 1'b0;
        check_empty("flush");
        push_one(vecs[7]);
        check_head("fl_repush", vecs[7].e);
        pop_one();

        // Pop while empty changes nothing.
        pop_one();
        check_empty("empty_pop");
        push_one(vecs[2]);
        check_head("empty_pop_next", vecs[2].e);
        pop_one();

        // Asynchronous reset mid-stream.
        push_one(vecs[5]);
        push_one(vecs[6]);
        #2;
        RESET_N = 1'b0;
        #1;
        check_empty("async_reset");
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check_empty("after_reset");

        // Randomized traffic against the queue model.
        model_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            check("rnd_empty", {79'd0, EMPTY_SE}, {79'd0, (model_q.size() == 0)});
            check("rnd_full",  {79'd0, FULL_SD},  {79'd0, (model_q.size() == DEPTH)});
            if (model_q.size() > 0) check_head("rnd", model_q[0]);
            else check("rnd_zero", {6'd0, OP1_SE, OP2_SE, CIN_SE, CMD_SE, RD_SE, WB_SE, ILLEGAL_SE}, 80'd0);

            rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            a  = $urandom();
            b  = $urandom();
            ins = $urandom();
            case ($urandom_range(0, 9))
                0: ins = {7'h00, ins[24:15], 3'd0, rd, 7'h33};
                1: ins = {7'h20, ins[24:15], 3'd0, rd, 7'h33};
                2: ins = {7'h00, ins[24:15], 3'd4, rd, 7'h33};
                3: ins = {7'h00, ins[24:15], 3'd6, rd, 7'h33};
                4: ins = {7'h00, ins[24:15], 3'd7, rd, 7'h33};
                5: ins = {ins[31:15], 3'd0, rd, 7'h13};
                6: ins = {ins[31:15], 3'd4, rd, 7'h13};
                7: ins = {ins[31:15], 3'd6, rd, 7'h13};
                8: ins = {ins[31:15], 3'd7, rd, 7'h13};
                default: ;
            endcase
            v = ($urandom_range(0, 3) != 0);
            p = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 19) == 0);

            INSTR_SD = ins; RS1_DATA_SD = a; RS2_DATA_SD = b;
            VALID_SD = v; POP_SE = p; FLUSH_SE = f;

            if (f) begin
                model_q.delete();
            end else begin
                do_push = v && (model_q.size() < DEPTH);
                do_pop  = p && (model_q.size() > 0);
                if (do_pop)  void'(model_q.pop_front());
                if (do_push) model_q.push_back(ref_decode(ins, a, b));
            end
            @(negedge CLK);
        end
        VALID_SD = 1'b0; POP_SE = 1'b0; FLUSH_SE = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
